freq_synth_gen: RTL

- Programmable square-wave generator: produces `sig` at a commanded frequency, in hundreds of Hz, derived from `clk`.
- It is the transmit-side counterpart of the period-counter frequency meter and drives the meter's `sig` input for bench and in-system self-test.
- A fractional (modulo-F_CLK) phase accumulator gives an exact long-term average frequency.
- Frequency changes are applied phase-continuously, at the next rising edge of `sig`.

---
 rtl/freq_synth_gen_if.sv | 38 +++
 rtl/freq_synth_gen.sv | 110 +++++++++++
 2 files changed

// File: rtl/freq_synth_gen_if.sv
// freq_synth_gen_if: control and status bundle of the programmable square-wave
// generator.
//   master (controller/bench): drives en, f_set and load; observes load_ack,
//                              sig, sig_rise, gate_done, f_active and n_cyc.
//   slave  (generator):        the mirror image of master.
// Signals:
//   en        output enable
//   f_set     requested frequency in hundreds of Hz (FW bits)
//   load      single-cycle strobe that captures f_set
//   load_ack  one-cycle pulse the cycle after load is sampled
//   sig       generated square wave
//   sig_rise  one-cycle pulse in the first cycle sig is high
//   gate_done one-cycle pulse on every M-th rising edge of sig
//   f_active  frequency currently being generated (FW bits)
//   n_cyc     rising-edge count within the current gate (7 bits)
interface freq_synth_gen_if #(
    parameter int FW = 14
);
    logic          en;
    logic [FW-1:0] f_set;
    logic          load;
    logic          load_ack;
    logic          sig;
    logic          sig_rise;
    logic          gate_done;
    logic [FW-1:0] f_active;
    logic [6:0]    n_cyc;

    modport master (
        output en, f_set, load,
        input  load_ack, sig, sig_rise, gate_done, f_active, n_cyc
    );

    modport slave (
        input  en, f_set, load,
        output load_ack, sig, sig_rise, gate_done, f_active, n_cyc
    );
endinterface

// File: rtl/freq_synth_gen.sv
// freq_synth_gen: programmable square-wave generator. A modulo-F_CLK phase
// accumulator advances by 2*f_active every clock and toggles sig on each wrap,
// so exactly f_active full periods are produced per F_CLK clocks (frequencies
// in hundreds of Hz). New frequencies are queued by a load strobe and applied
// phase-continuously on the clock that generates the next rising edge, or
// immediately while the generator is idle.
// Ports:
//   clk      system clock, rising edge
//   reset_n  synchronous active-low reset, highest priority
//   bus      freq_synth_gen_if slave modport (see interface file)
module freq_synth_gen #(
    parameter int F_CLK = 35795,  // clock frequency, hundreds of Hz
    parameter int M     = 50,     // rising edges per gate_done pulse
    parameter int FW    = 14,     // frequency word width
    parameter int AW    = 17      // accumulator width, 2^AW > 2*F_CLK
) (
    input  logic             clk,
    input  logic             reset_n,
    freq_synth_gen_if.slave  bus
);
    localparam logic [AW-1:0] F_CLK_W = AW'(F_CLK);
    localparam int            F_HALF  = F_CLK / 2;
    localparam logic [6:0]    M_LAST  = 7'(M - 1);

    // Highest frequency that still yields one toggle per clock at most.
    function automatic logic [FW-1:0] sat_half(input logic [FW-1:0] f);
        if (32'(f) > 32'(F_HALF)) begin
            return FW'(F_HALF);
        end
        return f;
    endfunction

    logic [AW-1:0] acc;
    logic [FW-1:0] f_pend;
    logic          pending;
    logic [FW-1:0] f_act;
    logic          sig_q;
    logic          sig_rise_q;
    logic          gate_done_q;
    logic          load_ack_q;
    logic [6:0]    n_cyc_q;

    logic          run;
    logic [AW-1:0] sum;
    logic          wrap;
    logic          rise_gen;

    // Accumulation only happens with the output enabled and a nonzero rate.
    assign run      = bus.en && (f_act != '0);
    assign sum      = acc + AW'({f_act, 1'b0});
    // acc < F_CLK always holds, so a single subtraction keeps it in range.
    assign wrap     = (sum >= F_CLK_W);
    assign rise_gen = run && wrap && !sig_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc         <= '0;
            f_pend      <= '0;
            pending     <= 1'b0;
            f_act       <= '0;
            sig_q       <= 1'b0;
            sig_rise_q  <= 1'b0;
            gate_done_q <= 1'b0;
            load_ack_q  <= 1'b0;
            n_cyc_q     <= '0;
        end else begin
            load_ack_q <= bus.load;

            if (run) begin
                if (wrap) begin
                    acc   <= sum - F_CLK_W;
                    sig_q <= ~sig_q;
                end else begin
                    acc <= sum;
                end
                sig_rise_q  <= rise_gen;
                gate_done_q <= rise_gen && (n_cyc_q == M_LAST);
                if (rise_gen) begin
                    n_cyc_q <= (n_cyc_q == M_LAST) ? 7'd0 : n_cyc_q + 7'd1;
                end
            end else begin
                acc         <= '0;
                sig_q       <= 1'b0;
                sig_rise_q  <= 1'b0;
                gate_done_q <= 1'b0;
                n_cyc_q     <= '0;
            end

            // The rate used for this clock's accumulation is the old one; the
            // applied value takes effect from the next accumulation.
            if (pending && (rise_gen || !run)) begin
                f_act   <= f_pend;
                pending <= 1'b0;
            end

            // A load coinciding with an apply queues behind it (last write wins).
            if (bus.load) begin
                f_pend  <= sat_half(bus.f_set);
                pending <= 1'b1;
            end
        end
    end

    assign bus.sig       = sig_q;
    assign bus.sig_rise  = sig_rise_q;
    assign bus.gate_done = gate_done_q;
    assign bus.load_ack  = load_ack_q;
    assign bus.f_active  = f_act;
    assign bus.n_cyc     = n_cyc_q;
endmodule
